wavetable_fetch: RTL and testbench

- Wavetable oscillator front end; sits directly upstream of the bilinear interpolator stage.
- On each sample tick it advances a 32-bit phase accumulator and reads four samples from the wavetable ROM: two adjacent samples from each of two adjacent tables.
- It presents those samples with a 16-bit sample-interp fraction and a 16-bit table-interp fraction, in exactly the operand arrangement the interpolator consumes.

---
 rtl/wt_pkg.sv | 16 +
 rtl/wavetable_fetch_if.sv | 13 +
 rtl/wt_phase_acc.sv | 27 ++
 rtl/wavetable_fetch.sv | 176 +++++++++++++++++
 tb/tb_wavetable_fetch.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/wt_pkg.sv
// Shared types and widths for the wavetable fetch front end.
package wt_pkg;
    localparam int DEF_ADDR_BITS  = 10;
    localparam int DEF_TABLE_BITS = 3;
    localparam int TABLE_AW       = DEF_TABLE_BITS + DEF_ADDR_BITS;
    localparam int FRAC_W         = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } wt_state_e;

    typedef logic [1:0] wt_slot_t;
endpackage

// File: rtl/wavetable_fetch_if.sv
// Wavetable ROM read port: the fetch engine is master, the ROM is slave.
interface wavetable_fetch_if
    import wt_pkg::*;
#(
    parameter int AW = TABLE_AW
);
    logic [AW-1:0] rom_addr;
    logic          rom_rd;
    logic [15:0]   rom_data;

    modport master (output rom_addr, output rom_rd, input rom_data);
    modport slave  (input rom_addr, input rom_rd, output rom_data);
endinterface

// File: rtl/wt_phase_acc.sv
// 32-bit phase accumulator; p is the phase the fetch accepted this cycle would use.
module wt_phase_acc (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ena,
    input  logic        sync,
    input  logic        accept,
    input  logic [31:0] phase_inc,
    output logic [31:0] p
);
    logic [31:0] phase_reg;

    // Hard-sync takes effect on the same tick it arrives with.
    assign p = sync ? 32'd0 : phase_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_reg <= '0;
        end else if (ena) begin
            if (accept) begin
                phase_reg <= p + phase_inc;
            end else if (sync) begin
                phase_reg <= '0;
            end
        end
    end
endmodule

// File: rtl/wavetable_fetch.sv
// Wavetable oscillator front end: per tick, fetches the 2x2 sample neighbourhood
// (two indices x two tables) and presents it with both interpolation fractions.
module wavetable_fetch
    import wt_pkg::*;
#(
    parameter int ADDR_BITS   = DEF_ADDR_BITS,
    parameter int TABLE_BITS  = DEF_TABLE_BITS,
    parameter int RAM_LATENCY = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    ena,
    input  logic                    tick,
    input  logic                    sync,
    input  logic [31:0]             phase_inc,
    input  logic [15:0]             table_pos,
    wavetable_fetch_if.master       rom,
    output logic [1:0][15:0]        samp_n,
    output logic [1:0][15:0]        samp_n1,
    output logic [FRAC_W-1:0]       sample_frac,
    output logic [FRAC_W-1:0]       table_frac,
    output logic                    out_valid,
    output logic                    busy,
    output logic                    overrun
);
    localparam logic [1:0] ST_IDLE  = IDLE;
    localparam logic [1:0] ST_ISSUE = ISSUE;
    localparam logic [1:0] ST_DRAIN = DRAIN;
    localparam logic [1:0] ST_DONE  = DONE;
    localparam logic [2:0] DRAIN_LAST = 3'(RAM_LATENCY - 1);

    logic [1:0]              state_reg;
    wt_slot_t                slot_reg;
    logic [2:0]              drain_reg;
    logic [TABLE_BITS-1:0]   t_reg, t1_reg, t_in, t1_in;
    logic [ADDR_BITS-1:0]    n_reg, n1;
    logic [FRAC_W-1:0]       sfrac_reg, tfrac_reg;
    logic [31:0]             p;
    logic                    phase_unused;
    logic                    accept, issuing, done_entry, capture;
    logic [TABLE_BITS+ADDR_BITS-1:0] addr_sel;
    logic                    tag_v_reg [RAM_LATENCY];
    wt_slot_t                tag_reg   [RAM_LATENCY];
    logic [15:0]             stage_reg  [4];
    logic [15:0]             stage_next [4];

    assign accept = ena && tick && (state_reg == ST_IDLE);

    wt_phase_acc u_phase_acc (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .sync      (sync),
        .accept    (accept),
        .phase_inc (phase_inc),
        .p         (p)
    );
    assign phase_unused = ^p;

    // Upper neighbour table saturates at the last table instead of wrapping.
    assign t_in  = table_pos[15 -: TABLE_BITS];
    assign t1_in = (t_in == {TABLE_BITS{1'b1}}) ? t_in : t_in + TABLE_BITS'(1);
    assign n1    = n_reg + ADDR_BITS'(1);

    always_comb begin
        addr_sel = {t_reg, n_reg};
        case (slot_reg)
            2'd0:    addr_sel = {t_reg,  n_reg};
            2'd1:    addr_sel = {t_reg,  n1};
            2'd2:    addr_sel = {t1_reg, n_reg};
            default: addr_sel = {t1_reg, n1};
        endcase
    end

    assign issuing      = (state_reg == ST_ISSUE);
    assign rom.rom_rd   = issuing && ena;
    assign rom.rom_addr = issuing ? addr_sel : '0;

    assign busy       = (state_reg != ST_IDLE);
    assign out_valid  = ena && (state_reg == ST_DONE);
    assign overrun    = ena && tick && busy;
    assign done_entry = ena && (state_reg == ST_DRAIN) && (drain_reg == DRAIN_LAST);
    assign capture    = ena && tag_v_reg[RAM_LATENCY-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            slot_reg  <= '0;
            drain_reg <= '0;
            t_reg     <= '0;
            t1_reg    <= '0;
            n_reg     <= '0;
            sfrac_reg <= '0;
            tfrac_reg <= '0;
        end else if (ena) begin
            case (state_reg)
                ST_IDLE: begin
                    if (tick) begin
                        state_reg <= ST_ISSUE;
                        slot_reg  <= '0;
                        t_reg     <= t_in;
                        t1_reg    <= t1_in;
                        n_reg     <= p[31 -: ADDR_BITS];
                        sfrac_reg <= p[31-ADDR_BITS -: FRAC_W];
                        tfrac_reg <= {table_pos[15-TABLE_BITS:0], {TABLE_BITS{1'b0}}};
                    end
                end
                ST_ISSUE: begin
                    slot_reg <= slot_reg + 2'd1;
                    if (slot_reg == 2'd3) begin
                        state_reg <= ST_DRAIN;
                        drain_reg <= '0;
                    end
                end
                ST_DRAIN: begin
                    drain_reg <= drain_reg + 3'd1;
                    if (drain_reg == DRAIN_LAST) begin
                        state_reg <= ST_DONE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    // Tag pipe mirrors the ROM pipeline so each returning word knows its slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RAM_LATENCY; i++) begin
                tag_v_reg[i] <= 1'b0;
                tag_reg[i]   <= '0;
            end
        end else if (ena) begin
            tag_v_reg[0] <= rom.rom_rd;
            tag_reg[0]   <= slot_reg;
            for (int i = 1; i < RAM_LATENCY; i++) begin
                tag_v_reg[i] <= tag_v_reg[i-1];
                tag_reg[i]   <= tag_reg[i-1];
            end
        end
    end

    // The last word lands on the same edge as DONE entry, so outputs load from stage_next.
    for (genvar gi = 0; gi < 4; gi++) begin : g_stage
        assign stage_next[gi] = (capture && (tag_reg[RAM_LATENCY-1] == wt_slot_t'(gi)))
                              ? rom.rom_data : stage_reg[gi];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                stage_reg[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                stage_reg[i] <= stage_next[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            samp_n      <= '0;
            samp_n1     <= '0;
            sample_frac <= '0;
            table_frac  <= '0;
        end else if (done_entry) begin
            samp_n[1]   <= stage_next[0];
            samp_n1[1]  <= stage_next[1];
            samp_n[0]   <= stage_next[2];
            samp_n1[0]  <= stage_next[3];
            sample_frac <= sfrac_reg;
            table_frac  <= tfrac_reg;
        end
    end
endmodule

// File: tb/tb_wavetable_fetch.sv
// Bench for wavetable_fetch: directed vector table plus randomized fetches against a phase/index model.
module tb_wavetable_fetch;
    localparam int L = 2;

    logic               clk = 1'b0;
    logic               rst_n, ena, tick, sync;
    logic [31:0]        phase_inc;
    logic [15:0]        table_pos;
    logic [1:0][15:0]   samp_n, samp_n1;
    logic [15:0]        sample_frac, table_frac;
    logic               out_valid, busy, overrun;
    logic [15:0]        rom_pipe [L];

    int n_cmp = 0;
    int n_fail = 0;
    bit [31:0] mphase;
    bit [63:0] prev_samp;

    wavetable_fetch_if #(.AW(13)) rif ();

    wavetable_fetch #(.ADDR_BITS(10), .TABLE_BITS(3), .RAM_LATENCY(L)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ena         (ena),
        .tick        (tick),
        .sync        (sync),
        .phase_inc   (phase_inc),
        .table_pos   (table_pos),
        .rom         (rif),
        .samp_n      (samp_n),
        .samp_n1     (samp_n1),
        .sample_frac (sample_frac),
        .table_frac  (table_frac),
        .out_valid   (out_valid),
        .busy        (busy),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] rom_val(input logic [12:0] a);
        return {3'b101, a};
    endfunction

    // ROM with L enabled cycles of read latency; not reset, so in-flight words survive a DUT reset.
    always @(posedge clk) begin
        if (ena) begin
            rom_pipe[0] <= rif.rom_rd ? rom_val(rif.rom_addr) : 16'h0000;
            for (int i = 1; i < L; i++) rom_pipe[i] <= rom_pipe[i-1];
        end
    end
    assign rif.rom_data = rom_pipe[L-1];

    typedef struct {
        bit              sy;
        bit [31:0]       inc;
        bit [15:0]       tp;
        int              drop1, drop2, stall_at, sync_mid, rst_at;
        bit [3:0][12:0]  a;
        bit [15:0]       sf, tf;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    // Reference: index/table arithmetic straight from the phase and morph position.
    task automatic model(input bit [31:0] p, input bit [15:0] tp,
                         output bit [3:0][12:0] a, output bit [15:0] sf, output bit [15:0] tf);
        int n, n1, t, t1;
        n  = int'(p / 32'd4194304);
        n1 = (n + 1) % 1024;
        t  = int'(tp) / 8192;
        t1 = (t < 7) ? t + 1 : 7;
        a[0] = 13'(t * 1024 + n);
        a[1] = 13'(t * 1024 + n1);
        a[2] = 13'(t1 * 1024 + n);
        a[3] = 13'(t1 * 1024 + n1);
        sf = 16'((p / 32'd64) % 32'd65536);
        tf = 16'((int'(tp) % 8192) * 8);
    endtask

    function automatic vec_t mk(input bit sy, input bit [31:0] inc, input bit [15:0] tp,
                                input int d1, input int d2, input int st, input int sm, input int rs,
                                input bit [12:0] a0, input bit [12:0] a1, input bit [12:0] a2,
                                input bit [12:0] a3, input bit [15:0] sf, input bit [15:0] tf);
        vec_t v;
        v.sy = sy; v.inc = inc; v.tp = tp;
        v.drop1 = d1; v.drop2 = d2; v.stall_at = st; v.sync_mid = sm; v.rst_at = rs;
        v.a[0] = a0; v.a[1] = a1; v.a[2] = a2; v.a[3] = a3;
        v.sf = sf; v.tf = tf;
        return v;
    endfunction

    task automatic run(input vec_t v, input bit use_tab, input int idx);
        bit [3:0][12:0] ea, ma, rec;
        bit [15:0] esf, etf, msf, mtf;
        bit [31:0] p;
        int got, nrd, exp_lat;
        got = 0; nrd = 0; rec = '0;
        exp_lat = 5 + L + ((v.stall_at > 0) ? 5 : 0);
        @(negedge clk);
        ena = 1'b1; tick = 1'b1; sync = v.sy; phase_inc = v.inc; table_pos = v.tp;
        #1;
        chk("idle_busy", busy, 1'b0);
        chk("valid_pulse", out_valid, 1'b0);
        p = v.sy ? 32'd0 : mphase;
        mphase = p + v.inc;
        model(p, v.tp, ma, msf, mtf);
        ea  = use_tab ? v.a  : ma;
        esf = use_tab ? v.sf : msf;
        etf = use_tab ? v.tf : mtf;
        for (int c = 1; c <= 60 && got == 0; c++) begin
            @(negedge clk);
            tick = 1'b0; sync = 1'b0;
            phase_inc = $urandom; table_pos = 16'($urandom);
            ena = !(v.stall_at > 0 && c >= v.stall_at && c < v.stall_at + 5);
            if (c == v.drop1 || c == v.drop2) tick = 1'b1;
            if (c == v.sync_mid) begin sync = 1'b1; mphase = 32'd0; end
            if (c == v.rst_at) begin
                tick = 1'b0; sync = 1'b0;
                rst_n = 1'b0;
                #1;
                chk("rst_samp", {samp_n, samp_n1}, 64'd0);
                chk("rst_frac", {sample_frac, table_frac}, 32'd0);
                chk("rst_rom", {rif.rom_addr, rif.rom_rd}, 14'd0);
                chk("rst_flags", {out_valid, busy, overrun}, 3'd0);
                @(negedge clk);
                rst_n = 1'b1;
                mphase = 32'd0;
                prev_samp = '0;
                $display("fetch %0d: reset at cycle %0d, outputs cleared", idx, c);
                return;
            end
            #1;
            if (tick) chk("overrun", overrun, 1'b1);
            if (!ena) chk("stall_rd", rif.rom_rd, 1'b0);
            if (rif.rom_rd && ena) begin
                if (nrd < 4) rec[nrd] = rif.rom_addr;
                nrd++;
            end
            if (c == 3) chk("hold", {samp_n, samp_n1}, prev_samp);
            if (out_valid) got = c;
        end
        chk("latency", got, exp_lat);
        chk("nreads", nrd, 4);
        for (int k = 0; k < 4; k++) chk($sformatf("addr%0d", k), rec[k], ea[k]);
        chk("samp_n_t",   samp_n[1],  rom_val(ea[0]));
        chk("samp_n1_t",  samp_n1[1], rom_val(ea[1]));
        chk("samp_n_t1",  samp_n[0],  rom_val(ea[2]));
        chk("samp_n1_t1", samp_n1[0], rom_val(ea[3]));
        chk("sample_frac", sample_frac, esf);
        chk("table_frac",  table_frac,  etf);
        prev_samp = {rom_val(ea[0]), rom_val(ea[2]), rom_val(ea[1]), rom_val(ea[3])};
        $display("fetch %0d: p=%h tp=%h lat=%0d addr=%h %h %h %h sf=%h tf=%h",
                 idx, p, v.tp, got, rec[0], rec[1], rec[2], rec[3], sample_frac, table_frac);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vt [12];
        vec_t vr;
        vt[0]  = mk(1, 32'h0040_0000, 16'h2000, 0, 0, 0, 0, 0, 13'h400, 13'h401, 13'h800, 13'h801, 16'h0000, 16'h0000);
        vt[1]  = mk(0, 32'h0040_0000, 16'h2000, 0, 0, 0, 0, 0, 13'h401, 13'h402, 13'h801, 13'h802, 16'h0000, 16'h0000);
        vt[2]  = mk(1, 32'hFFC0_0000, 16'h2000, 0, 0, 0, 0, 0, 13'h400, 13'h401, 13'h800, 13'h801, 16'h0000, 16'h0000);
        vt[3]  = mk(0, 32'hFFC0_0000, 16'h2000, 0, 0, 0, 0, 0, 13'h7FF, 13'h400, 13'hBFF, 13'h800, 16'h0000, 16'h0000);
        vt[4]  = mk(1, 32'h0060_0000, 16'hFFFF, 0, 0, 0, 0, 0, 13'h1C00, 13'h1C01, 13'h1C00, 13'h1C01, 16'h0000, 16'hFFF8);
        vt[5]  = mk(0, 32'h0060_0000, 16'hFFFF, 0, 0, 0, 0, 0, 13'h1C01, 13'h1C02, 13'h1C01, 13'h1C02, 16'h8000, 16'hFFF8);
        vt[6]  = mk(1, 32'h0040_0000, 16'h4000, 3, 7, 0, 0, 0, 13'h800, 13'h801, 13'hC00, 13'hC01, 16'h0000, 16'h0000);
        vt[7]  = mk(0, 32'h0040_0000, 16'h4000, 0, 0, 0, 2, 0, 13'h801, 13'h802, 13'hC01, 13'hC02, 16'h0000, 16'h0000);
        vt[8]  = mk(0, 32'h0040_0000, 16'h4000, 0, 0, 0, 0, 0, 13'h800, 13'h801, 13'hC00, 13'hC01, 16'h0000, 16'h0000);
        vt[9]  = mk(1, 32'h0040_0000, 16'h6000, 0, 0, 2, 0, 0, 13'hC00, 13'hC01, 13'h1000, 13'h1001, 16'h0000, 16'h0000);
        vt[10] = mk(1, 32'h0040_0000, 16'h2000, 0, 0, 0, 0, 5, 13'h0, 13'h0, 13'h0, 13'h0, 16'h0000, 16'h0000);
        vt[11] = mk(0, 32'h0040_0000, 16'h2000, 0, 0, 0, 0, 0, 13'h400, 13'h401, 13'h800, 13'h801, 16'h0000, 16'h0000);

        rst_n = 1'b0; ena = 1'b1; tick = 1'b0; sync = 1'b0;
        phase_inc = '0; table_pos = '0;
        mphase = '0; prev_samp = '0;
        repeat (3) @(negedge clk);
        #1;
        chk("init_samp", {samp_n, samp_n1}, 64'd0);
        chk("init_frac", {sample_frac, table_frac}, 32'd0);
        chk("init_rom", {rif.rom_addr, rif.rom_rd}, 14'd0);
        chk("init_flags", {out_valid, busy, overrun}, 3'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++) run(vt[i], 1'b1, i);

        for (int i = 0; i < 24; i++) begin
            vr = mk($urandom_range(3) == 0, $urandom, 16'($urandom),
                    ($urandom_range(1) == 1) ? int'($urandom_range(7, 1)) : 0,
                    0, 0, 0, 0, 13'h0, 13'h0, 13'h0, 13'h0, 16'h0, 16'h0);
            run(vr, 1'b0, 12 + i);
        end

        @(negedge clk);
        tick = 1'b0; sync = 1'b0;
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
